uart_rx_ctrl: RTL and testbench

Controller for the UART receive datapath.
- Generates the 16x-oversample clock enable that paces the receiver from a programmable divisor.
- Runs the READY/READY_CLR handshake with the receiver and buffers received bytes in a small FIFO for a downstream consumer.
- Flags overrun when a byte arrives with the FIFO full.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync_fifo.sv | 76 +++++++
 rtl/uart_rx_ctrl.sv | 125 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds data widths, oversample ratio and the RX handshake state encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int BYTE_W     = 8;

    // Baud divisor for a given line rate:
    //   DIVISOR = f_clk / (OVERSAMPLE * baud)

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk/rst, push/din, pop, dout (head), full, empty, count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = BYTE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    // A push into a full FIFO is accepted only when a pop frees the slot
    // in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    // Head is forced to zero when empty so reset leaves a clean output.
    assign dout  = empty ? '0 : mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud enable, READY/CLR handshake, byte FIFO.
// Ports: DIVISOR/RX_EN -> RX_CLK_EN; RX_READY/RX_DATA -> RX_READY_CLR; POP/DOUT/VALID/COUNT; OVERRUN/OVR_CLR.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DIV_W-1:0]         DIVISOR,
    input  logic                     RX_EN,
    output logic                     RX_CLK_EN,
    input  logic                     RX_READY,
    input  logic [BYTE_W-1:0]        RX_DATA,
    output logic                     RX_READY_CLR,
    input  logic                     POP,
    output logic [BYTE_W-1:0]        DOUT,
    output logic                     VALID,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERRUN,
    input  logic                     OVR_CLR
);

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;

    rx_state_e        state_q, state_d;
    logic             clr_q, clr_d;
    logic             push_req;
    logic             ovr_q, ovr_d;
    logic             ovr_set;

    logic             fifo_full;
    logic             fifo_empty;

    assign div_eff = (DIVISOR == '0) ? DIV_W'(1) : DIVISOR;

    // The >= compare makes a divisor decrease below the running count
    // wrap immediately instead of running to the counter's top.
    always_comb begin
        cnt_d = '0;
        en_d  = 1'b0;
        if (RX_EN) begin
            if (cnt_q >= div_eff - DIV_W'(1)) begin
                cnt_d = '0;
                en_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // ACK ignores RX_READY: it still shows the value from before the clear.
    always_comb begin
        state_d  = state_q;
        clr_d    = 1'b0;
        push_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (RX_READY) begin
                    push_req = 1'b1;
                    clr_d    = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A coincident pop keeps the full FIFO able to take the byte.
    assign ovr_set = push_req && fifo_full && !POP;

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (OVR_CLR) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            en_q    <= 1'b0;
            state_q <= IDLE;
            clr_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            state_q <= state_d;
            clr_q   <= clr_d;
            ovr_q   <= ovr_d;
        end
    end

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push_req),
        .din   (RX_DATA),
        .pop   (POP),
        .dout  (DOUT),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (COUNT)
    );

    assign RX_CLK_EN    = en_q;
    assign RX_READY_CLR = clr_q;
    assign VALID        = !fifo_empty;
    assign OVERRUN      = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl.
// Baud generator from a vector table; handshake/FIFO/reset by directed sequences.
module tb_uart_rx_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] DIVISOR = 16'd4;
    logic        RX_EN = 1'b0;
    logic        RX_CLK_EN;
    logic        RX_READY = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_READY_CLR;
    logic        POP = 1'b0;
    logic [7:0]  DOUT;
    logic        VALID;
    logic [4:0]  COUNT;
    logic        OVERRUN;
    logic        OVR_CLR = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.DEPTH(16), .DIV_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .DIVISOR      (DIVISOR),
        .RX_EN        (RX_EN),
        .RX_CLK_EN    (RX_CLK_EN),
        .RX_READY     (RX_READY),
        .RX_DATA      (RX_DATA),
        .RX_READY_CLR (RX_READY_CLR),
        .POP          (POP),
        .DOUT         (DOUT),
        .VALID        (VALID),
        .COUNT        (COUNT),
        .OVERRUN      (OVERRUN),
        .OVR_CLR      (OVR_CLR)
    );

    typedef struct {
        logic        rx_en;
        logic [15:0] div;
        logic        exp_en;
    } baud_vec_t;

    baud_vec_t bv [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bv(input int i, input logic en, input logic [15:0] d, input logic e);
        bv[i].rx_en  = en;
        bv[i].div    = d;
        bv[i].exp_en = e;
    endtask

    // Receiver model: READY high through the capture edge and the
    // following (clear) edge, then dropped.
    task automatic send_byte(input logic [7:0] b, input logic pop, input logic oclr);
        RX_READY = 1'b1;
        RX_DATA  = b;
        POP      = pop;
        OVR_CLR  = oclr;
        tick();
        POP      = 1'b0;
        OVR_CLR  = 1'b0;
        check("clr_pulse", {31'd0, RX_READY_CLR}, 32'd1);
        tick();
        check("clr_drop", {31'd0, RX_READY_CLR}, 32'd0);
        RX_READY = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) set_bv(i, 1'b1, 16'd4, 1'b0);
        set_bv(3, 1'b1, 16'd4, 1'b1);
        for (int i = 4; i < 7; i++) set_bv(i, 1'b1, 16'd4, 1'b0);
        set_bv(7, 1'b1, 16'd4, 1'b1);
        for (int i = 8; i < 11; i++) set_bv(i, 1'b1, 16'd4, 1'b0);
        set_bv(11, 1'b1, 16'd2, 1'b1);
        set_bv(12, 1'b1, 16'd2, 1'b0);
        set_bv(13, 1'b1, 16'd2, 1'b1);
        set_bv(14, 1'b1, 16'd2, 1'b0);
        set_bv(15, 1'b1, 16'd2, 1'b1);
        for (int i = 16; i < 19; i++) set_bv(i, 1'b0, 16'd2, 1'b0);
        for (int i = 19; i < 22; i++) set_bv(i, 1'b1, 16'd1, 1'b1);
        set_bv(22, 1'b1, 16'd0, 1'b1);

        // reset state
        #1;
        check("rst_clk_en", {31'd0, RX_CLK_EN}, 32'd0);
        check("rst_clr", {31'd0, RX_READY_CLR}, 32'd0);
        check("rst_valid", {31'd0, VALID}, 32'd0);
        check("rst_count", {27'd0, COUNT}, 32'd0);
        check("rst_ovr", {31'd0, OVERRUN}, 32'd0);
        check("rst_dout", {24'd0, DOUT}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("idle_no_en", {31'd0, RX_CLK_EN}, 32'd0);

        // baud generator table
        for (int i = 0; i < 23; i++) begin
            RX_EN   = bv[i].rx_en;
            DIVISOR = bv[i].div;
            tick();
            check($sformatf("baud[%0d]", i), {31'd0, RX_CLK_EN}, {31'd0, bv[i].exp_en});
        end
        RX_EN = 1'b0;
        tick();

        // single byte
        RX_READY = 1'b1;
        RX_DATA  = 8'hA5;
        tick();
        check("a5_clr", {31'd0, RX_READY_CLR}, 32'd1);
        check("a5_valid", {31'd0, VALID}, 32'd1);
        check("a5_dout", {24'd0, DOUT}, 32'hA5);
        check("a5_count", {27'd0, COUNT}, 32'd1);
        tick();
        check("a5_clr_off", {31'd0, RX_READY_CLR}, 32'd0);
        check("a5_no_dup", {27'd0, COUNT}, 32'd1);
        RX_READY = 1'b0;
        POP = 1'b1;
        tick();
        POP = 1'b0;
        check("a5_pop_valid", {31'd0, VALID}, 32'd0);
        check("a5_pop_count", {27'd0, COUNT}, 32'd0);

        // back-to-back: READY re-set on the clear edge
        RX_READY = 1'b1;
        RX_DATA  = 8'h11;
        tick();
        check("b2b_clr1", {31'd0, RX_READY_CLR}, 32'd1);
        tick();
        check("b2b_gap", {31'd0, RX_READY_CLR}, 32'd0);
        check("b2b_cnt1", {27'd0, COUNT}, 32'd1);
        RX_DATA = 8'h22;
        tick();
        check("b2b_clr2", {31'd0, RX_READY_CLR}, 32'd1);
        check("b2b_cnt2", {27'd0, COUNT}, 32'd2);
        tick();
        check("b2b_clr2_off", {31'd0, RX_READY_CLR}, 32'd0);
        RX_READY = 1'b0;
        check("b2b_head1", {24'd0, DOUT}, 32'h11);
        POP = 1'b1;
        tick();
        check("b2b_head2", {24'd0, DOUT}, 32'h22);
        tick();
        POP = 1'b0;
        check("b2b_empty", {27'd0, COUNT}, 32'd0);

        // fill and overrun
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
        check("fill_count", {27'd0, COUNT}, 32'd16);
        send_byte(8'hFF, 1'b0, 1'b0);
        check("ovr_set", {31'd0, OVERRUN}, 32'd1);
        check("ovr_count", {27'd0, COUNT}, 32'd16);
        check("ovr_head", {24'd0, DOUT}, 32'h00);
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        check("ovr_clr", {31'd0, OVERRUN}, 32'd0);
        send_byte(8'hFF, 1'b1, 1'b0);
        check("full_pp_ovr", {31'd0, OVERRUN}, 32'd0);
        check("full_pp_count", {27'd0, COUNT}, 32'd16);
        check("full_pp_head", {24'd0, DOUT}, 32'h01);

        // set wins over clear
        send_byte(8'hEE, 1'b0, 1'b0);
        check("ovr_again", {31'd0, OVERRUN}, 32'd1);
        send_byte(8'hEE, 1'b0, 1'b1);
        check("ovr_set_wins", {31'd0, OVERRUN}, 32'd1);
        OVR_CLR = 1'b1;
        tick();
        OVR_CLR = 1'b0;
        check("ovr_clr_alone", {31'd0, OVERRUN}, 32'd0);

        // drain in order: 01..0F then FF
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] e;
            e = (i == 16) ? 8'hFF : 8'(i);
            check($sformatf("drain[%0d]", i), {24'd0, DOUT}, {24'd0, e});
            POP = 1'b1;
            tick();
            POP = 1'b0;
        end
        check("drain_count", {27'd0, COUNT}, 32'd0);

        // pop on empty
        POP = 1'b1;
        tick();
        POP = 1'b0;
        check("pop_empty_cnt", {27'd0, COUNT}, 32'd0);
        check("pop_empty_vld", {31'd0, VALID}, 32'd0);
        send_byte(8'h3C, 1'b0, 1'b0);
        check("after_pe_head", {24'd0, DOUT}, 32'h3C);
        check("after_pe_cnt", {27'd0, COUNT}, 32'd1);
        POP = 1'b1;
        tick();
        POP = 1'b0;

        // async reset with COUNT=5, FSM in ACK
        RX_EN   = 1'b1;
        DIVISOR = 16'd1;
        for (int i = 0; i < 4; i++) send_byte(8'h40 + 8'(i), 1'b0, 1'b0);
        RX_READY = 1'b1;
        RX_DATA  = 8'h55;
        tick();
        check("pre_rst_cnt", {27'd0, COUNT}, 32'd5);
        check("pre_rst_clr", {31'd0, RX_READY_CLR}, 32'd1);
        check("pre_rst_en", {31'd0, RX_CLK_EN}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check("arst_cnt", {27'd0, COUNT}, 32'd0);
        check("arst_valid", {31'd0, VALID}, 32'd0);
        check("arst_clr", {31'd0, RX_READY_CLR}, 32'd0);
        check("arst_en", {31'd0, RX_CLK_EN}, 32'd0);
        check("arst_dout", {24'd0, DOUT}, 32'd0);
        tick();
        #1;
        RST = 1'b0;
        tick();
        check("post_rst_cnt", {27'd0, COUNT}, 32'd1);
        check("post_rst_head", {24'd0, DOUT}, 32'h55);
        check("post_rst_clr", {31'd0, RX_READY_CLR}, 32'd1);
        tick();
        RX_READY = 1'b0;
        RX_EN    = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
